// File: rtl/ex_stage_fwd_mul_pkg.sv
// Shared encodings for the execute stage: op codes,
// forwarding selects and the multiply FSM states.
package ex_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_MEMWB  = 2'b01;
   localparam logic [1:0] FWD_EXMEM  = 2'b10;
   localparam logic [1:0] FWD_NEWEST = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/ex_stage_fwd_mul_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock,
// product exposes the accumulator including the current bit.
module mul_seq
   import ex_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              last,
   output logic [DATA_W-1:0] product
);

   localparam int CW = $clog2(DATA_W);

   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_next;
   logic [CW-1:0]     cnt;

   always_comb begin
      acc_next = acc;
      if (b_q[cnt]) begin
         acc_next = acc + (a_q << cnt);
      end
   end

   assign last    = busy && (cnt == CW'(DATA_W - 1));
   assign product = acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (abort) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         a_q  <= a;
         b_q  <= b;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         acc <= acc_next;
         cnt <= cnt + CW'(1);
         if (last) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ex_stage_fwd_mul.sv
// Execute stage: operand forwarding, single-cycle ALU and an
// iterative multiply that stalls the front end while in flight.
module ex_stage_fwd_mul
   import ex_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   input  logic [DATA_W-1:0] imm,
   input  logic              alu_src,
   input  logic [4:0]        rd_in,
   input  logic              reg_write_in,
   input  logic [1:0]        forwardA,
   input  logic [1:0]        forwardB,
   input  logic [DATA_W-1:0] alu_out_EXMEM,
   input  logic [DATA_W-1:0] wb_data_MEMWB,
   input  logic              flush,
   output logic              stall_out,
   output logic [DATA_W-1:0] ex_result,
   output logic [4:0]        rd_out,
   output logic              reg_write_out,
   output logic              valid_out
);

   logic [DATA_W-1:0] a_fwd;
   logic [DATA_W-1:0] b_fwd;
   logic [DATA_W-1:0] b_op;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] product;
   logic              slt;
   logic              is_mul;
   logic              start;
   logic              mul_busy;
   logic              mul_last;
   logic              rw_pend;
   state_t            state;
   state_t            state_nx;

   always_comb begin
      unique case (forwardA)
         FWD_RF:     a_fwd = rs1_data;
         FWD_MEMWB:  a_fwd = wb_data_MEMWB;
         FWD_EXMEM:  a_fwd = alu_out_EXMEM;
         FWD_NEWEST: a_fwd = alu_out_EXMEM;
         default:    a_fwd = rs1_data;
      endcase
   end

   always_comb begin
      unique case (forwardB)
         FWD_RF:     b_fwd = rs2_data;
         FWD_MEMWB:  b_fwd = wb_data_MEMWB;
         FWD_EXMEM:  b_fwd = alu_out_EXMEM;
         FWD_NEWEST: b_fwd = alu_out_EXMEM;
         default:    b_fwd = rs2_data;
      endcase
   end

   assign b_op   = alu_src ? imm : b_fwd;
   assign slt    = $signed(a_fwd) < $signed(b_op);
   assign is_mul = (op == OP_MUL);

   always_comb begin
      alu_res = '0;
      unique case (op)
         OP_ADD:  alu_res = a_fwd + b_op;
         OP_SUB:  alu_res = a_fwd - b_op;
         OP_AND:  alu_res = a_fwd & b_op;
         OP_OR:   alu_res = a_fwd | b_op;
         OP_XOR:  alu_res = a_fwd ^ b_op;
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt};
         OP_MUL:  alu_res = '0;
         OP_RSV:  alu_res = '0;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_nx  = state;
      stall_out = 1'b0;
      start     = 1'b0;
      unique case (state)
         IDLE: begin
            if (valid_in && is_mul && !flush) begin
               state_nx  = BUSY;
               start     = 1'b1;
               stall_out = 1'b1;
            end
         end
         BUSY: begin
            if (flush || mul_last) begin
               state_nx = IDLE;
            end
            stall_out = mul_busy && !mul_last;
         end
         default: state_nx = IDLE;
      endcase
      // Kills and resets must never hold the front end.
      if (rst || flush) begin
         stall_out = 1'b0;
      end
   end

   mul_seq #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (flush),
      .a       (a_fwd),
      .b       (b_op),
      .busy    (mul_busy),
      .last    (mul_last),
      .product (product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ex_result     <= '0;
         rd_out        <= '0;
         reg_write_out <= 1'b0;
         valid_out     <= 1'b0;
         rw_pend       <= 1'b0;
      end else begin
         state         <= state_nx;
         reg_write_out <= 1'b0;
         valid_out     <= 1'b0;
         if (!flush) begin
            unique case (state)
               IDLE: begin
                  if (valid_in && is_mul) begin
                     rd_out  <= rd_in;
                     rw_pend <= reg_write_in;
                  end else if (valid_in) begin
                     ex_result     <= alu_res;
                     rd_out        <= rd_in;
                     reg_write_out <= reg_write_in;
                     valid_out     <= 1'b1;
                  end
               end
               BUSY: begin
                  if (mul_last) begin
                     ex_result     <= product;
                     reg_write_out <= rw_pend;
                     valid_out     <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_stage_fwd_mul.sv
// Self-checking bench for ex_stage_fwd_mul: directed vectors,
// multi-cycle multiply/flush/reset sequences and random ALU ops.
module tb_ex_stage_fwd_mul;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid_in = 1'b0;
   logic [2:0]    op = '0;
   logic [W-1:0]  rs1_data = '0;
   logic [W-1:0]  rs2_data = '0;
   logic [W-1:0]  imm = '0;
   logic          alu_src = 1'b0;
   logic [4:0]    rd_in = '0;
   logic          reg_write_in = 1'b0;
   logic [1:0]    forwardA = '0;
   logic [1:0]    forwardB = '0;
   logic [W-1:0]  alu_out_EXMEM = '0;
   logic [W-1:0]  wb_data_MEMWB = '0;
   logic          flush = 1'b0;
   logic          stall_out;
   logic [W-1:0]  ex_result;
   logic [4:0]    rd_out;
   logic          reg_write_out;
   logic          valid_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] rs1;
      logic [W-1:0] rs2;
      logic [W-1:0] imm;
      logic         asrc;
      logic [1:0]   fa;
      logic [1:0]   fb;
      logic [W-1:0] exm;
      logic [W-1:0] wb;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vt [11];

   ex_stage_fwd_mul #(.DATA_W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_in      (valid_in),
      .op            (op),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .imm           (imm),
      .alu_src       (alu_src),
      .rd_in         (rd_in),
      .reg_write_in  (reg_write_in),
      .forwardA      (forwardA),
      .forwardB      (forwardB),
      .alu_out_EXMEM (alu_out_EXMEM),
      .wb_data_MEMWB (wb_data_MEMWB),
      .flush         (flush),
      .stall_out     (stall_out),
      .ex_result     (ex_result),
      .rd_out        (rd_out),
      .reg_write_out (reg_write_out),
      .valid_out     (valid_out)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] pick(input logic [1:0] s,
         input logic [W-1:0] rf, input logic [W-1:0] ex,
         input logic [W-1:0] wb);
      if (s == 2'b00) return rf;
      if (s == 2'b01) return wb;
      return ex;
   endfunction

   function automatic logic [W-1:0] ref_alu(input logic [2:0] o,
         input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      case (o)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         3'd6: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return p[W-1:0];
         end
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act,
         input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] o, input logic [W-1:0] a,
         input logic [W-1:0] b, input logic [W-1:0] im,
         input logic src, input logic [1:0] fa, input logic [1:0] fb,
         input logic [W-1:0] exm, input logic [W-1:0] wb,
         input logic [4:0] rd, input logic rw);
      valid_in      = 1'b1;
      op            = o;
      rs1_data      = a;
      rs2_data      = b;
      imm           = im;
      alu_src       = src;
      forwardA      = fa;
      forwardB      = fb;
      alu_out_EXMEM = exm;
      wb_data_MEMWB = wb;
      rd_in         = rd;
      reg_write_in  = rw;
   endtask

   task automatic issue_vec(input string name, input vec_t v,
         input logic [4:0] rd, input logic rw);
      @(negedge clk);
      drive(v.op, v.rs1, v.rs2, v.imm, v.asrc, v.fa, v.fb,
            v.exm, v.wb, rd, rw);
      #1;
      chk({name, ".stall"}, W'(stall_out), W'(0));
      @(negedge clk);
      valid_in = 1'b0;
      chk({name, ".res"}, ex_result, v.exp);
      chk({name, ".valid"}, W'(valid_out), W'(1));
      chk({name, ".rd"}, W'(rd_out), W'(rd));
      chk({name, ".rw"}, W'(reg_write_out), W'(rw));
   endtask

   task automatic run_mul(input string name, input logic [W-1:0] a,
         input logic [W-1:0] b, input bit toggle);
      logic [W-1:0] exp;
      int stalls;
      bit badv;
      exp = ref_alu(3'd6, a, b);
      stalls = 0;
      badv = 0;
      @(negedge clk);
      drive(3'd6, a, b, '0, 1'b0, 2'b00, 2'b00, $urandom, $urandom,
            5'd17, 1'b1);
      #1;
      for (int i = 0; i < 40; i++) begin
         if (!stall_out) break;
         stalls++;
         @(negedge clk);
         if (toggle) begin
            forwardA      = 2'($urandom);
            alu_out_EXMEM = $urandom;
            wb_data_MEMWB = $urandom;
            rs1_data      = $urandom;
         end
         #1;
         if (valid_out) badv = 1;
      end
      chk({name, ".stall_cycles"}, W'(stalls), W'(W));
      chk({name, ".no_early_valid"}, W'(badv), W'(0));
      @(negedge clk);
      valid_in = 1'b0;
      chk({name, ".res"}, ex_result, exp);
      chk({name, ".valid"}, W'(valid_out), W'(1));
      chk({name, ".rd"}, W'(rd_out), W'(17));
      chk({name, ".rw"}, W'(reg_write_out), W'(1));
   endtask

   task automatic start_mul(input int n);
      @(negedge clk);
      drive(3'd6, 32'd7, 32'd9, '0, 1'b0, 2'b00, 2'b00, '0, '0,
            5'd9, 1'b1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] held;
      vec_t v;
      bit badv;

      vt[0]  = '{3'd0, 5, 3, 0, 0, 2'b10, 2'b00, 100, 0, 103};
      vt[1]  = '{3'd1, 0, 0, 0, 0, 2'b11, 2'b01, 50, 7, 43};
      vt[2]  = '{3'd1, 0, 0, 2, 1, 2'b11, 2'b01, 50, 7, 48};
      vt[3]  = '{3'd5, 32'hFFFF_FFFF, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1};
      vt[4]  = '{3'd5, 1, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 0, 0};
      vt[5]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 2'b00,
                 2'b00, 0, 0, 32'hF000_F000};
      vt[6]  = '{3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 2'b00,
                 2'b00, 0, 0, 32'hFFF0_FFF0};
      vt[7]  = '{3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 2'b00,
                 2'b00, 0, 0, 32'h0FF0_0FF0};
      vt[8]  = '{3'd7, 5, 3, 0, 0, 2'b00, 2'b00, 0, 0, 0};
      vt[9]  = '{3'd1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF};
      vt[10] = '{3'd0, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 2'b01, 0, 2, 1};

      // reset state, with a MUL presented to prove stall stays low
      drive(3'd6, 3, 4, 0, 0, 2'b00, 2'b00, 0, 0, 5'd3, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      chk("rst.stall", W'(stall_out), W'(0));
      chk("rst.res", ex_result, W'(0));
      chk("rst.rd", W'(rd_out), W'(0));
      chk("rst.rw", W'(reg_write_out), W'(0));
      chk("rst.valid", W'(valid_out), W'(0));
      valid_in = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         issue_vec($sformatf("vec%0d", i), vt[i], 5'(i + 1), i[0]);
      end

      @(negedge clk);
      chk("idle.valid_drop", W'(valid_out), W'(0));
      chk("idle.rw_drop", W'(reg_write_out), W'(0));
      chk("idle.res_hold", ex_result, vt[10].exp);

      run_mul("mul_a", 32'h0001_0003, 32'd5, 1'b0);
      run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_mul("mul_tog", 32'h0000_1234, 32'h0000_5678, 1'b1);
      run_mul("mul_rnd", $urandom, $urandom, 1'b1);

      // flush in the middle of a multiply
      issue_vec("pre_flush", vt[0], 5'd1, 1'b1);
      start_mul(10);
      flush = 1'b1;
      #1;
      chk("flush.stall", W'(stall_out), W'(0));
      @(negedge clk);
      flush = 1'b0;
      valid_in = 1'b0;
      chk("flush.valid", W'(valid_out), W'(0));
      chk("flush.rw", W'(reg_write_out), W'(0));
      badv = 0;
      repeat (30) begin
         @(negedge clk);
         if (valid_out || stall_out) badv = 1;
      end
      chk("flush.no_result", W'(badv), W'(0));
      chk("flush.res_hold", ex_result, vt[0].exp);
      issue_vec("post_flush", vt[1], 5'd2, 1'b1);

      // flush beats a valid ADD in the same cycle
      held = ex_result;
      @(negedge clk);
      drive(3'd0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 5'd4, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      valid_in = 1'b0;
      chk("flush_add.valid", W'(valid_out), W'(0));
      chk("flush_add.rw", W'(reg_write_out), W'(0));
      chk("flush_add.res", ex_result, held);

      // reset in the middle of a multiply
      start_mul(20);
      rst = 1'b1;
      #1;
      chk("rst_mul.stall", W'(stall_out), W'(0));
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      chk("rst_mul.res", ex_result, W'(0));
      chk("rst_mul.rd", W'(rd_out), W'(0));
      chk("rst_mul.rw", W'(reg_write_out), W'(0));
      chk("rst_mul.valid", W'(valid_out), W'(0));
      issue_vec("post_rst", vt[0], 5'd6, 1'b1);

      // random single-cycle ops against the reference model
      for (int i = 0; i < 40; i++) begin
         v.op = 3'($urandom_range(0, 6));
         if (v.op == 3'd6) v.op = 3'd7;
         v.rs1  = $urandom;
         v.rs2  = $urandom;
         v.imm  = $urandom;
         v.asrc = 1'($urandom);
         v.fa   = 2'($urandom);
         v.fb   = 2'($urandom);
         v.exm  = $urandom;
         v.wb   = $urandom;
         v.exp  = ref_alu(v.op, pick(v.fa, v.rs1, v.exm, v.wb),
            v.asrc ? v.imm : pick(v.fb, v.rs2, v.exm, v.wb));
         issue_vec($sformatf("rnd%0d", i), v, 5'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
